// File: rtl/register_file.sv
// 32 x 64-bit register file: one byte-lane-masked write port, two combinational
// read ports with write-through forwarding, asynchronous active-high clear.
// Vectors are big-endian: bit 0 is the MSB and byte k occupies bits [8k:8k+7].
module register_file #(
  parameter int ADDR_WIDTH = 5,  // register address width (2**ADDR_WIDTH entries)
  parameter int DATA_WIDTH = 64  // register width in bits (byte-lane logic assumes 64)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [0:2]            sel,
  input  logic [0:DATA_WIDTH-1] data_in,
  input  logic [0:ADDR_WIDTH-1] addr_wr,
  input  logic [0:ADDR_WIDTH-1] addr_rd_0,
  input  logic [0:ADDR_WIDTH-1] addr_rd_1,
  output logic [0:DATA_WIDTH-1] data_out_0,
  output logic [0:DATA_WIDTH-1] data_out_1
);

  localparam int NumRegs  = 2 ** ADDR_WIDTH;
  localparam int NumBytes = DATA_WIDTH / 8;

  logic [0:DATA_WIDTH-1] regs [NumRegs];
  logic [0:NumBytes-1]   byte_en;
  logic [0:DATA_WIDTH-1] wr_old;
  logic [0:DATA_WIDTH-1] merged;
  logic                  wr_active;

  // Decode sel into per-byte write enables; reserved codes enable nothing.
  always_comb begin
    byte_en = '0;
    for (int k = 0; k < NumBytes; k++) begin
      unique case (sel)
        3'b000:  byte_en[k] = 1'b1;
        3'b001:  byte_en[k] = (k < NumBytes / 2);
        3'b010:  byte_en[k] = (k >= NumBytes / 2);
        3'b011:  byte_en[k] = (k % 2 == 0);
        3'b100:  byte_en[k] = (k % 2 == 1);
        default: byte_en[k] = 1'b0;
      endcase
    end
  end

  // Merge new bytes over the current contents of the target register.
  always_comb begin
    wr_old = regs[addr_wr];
    merged = wr_old;
    for (int k = 0; k < NumBytes; k++) begin
      if (byte_en[k]) begin
        merged[8*k +: 8] = data_in[8*k +: 8];
      end
    end
  end

  // A write held off by reset must not be forwarded either.
  assign wr_active = we && !reset;

  // Register array: asynchronous clear, whole-word store of the merged value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[addr_wr] <= merged;
    end
  end

  // Zero-latency reads, forwarding the in-flight merged write on address match.
  always_comb begin
    data_out_0 = regs[addr_rd_0];
    data_out_1 = regs[addr_rd_1];
    if (wr_active && (addr_rd_0 == addr_wr)) begin
      data_out_0 = merged;
    end
    if (wr_active && (addr_rd_1 == addr_wr)) begin
      data_out_1 = merged;
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus pushes expected read data into a
// queue, a negedge monitor pops and compares against both read ports.
module tb_register_file;

  logic         clk;
  logic         reset;
  logic         we;
  logic [0:2]   sel;
  logic [0:63]  data_in;
  logic [0:4]   addr_wr;
  logic [0:4]   addr_rd_0;
  logic [0:4]   addr_rd_1;
  logic [0:63]  data_out_0;
  logic [0:63]  data_out_1;

  register_file #(
    .ADDR_WIDTH(5),
    .DATA_WIDTH(64)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .we        (we),
    .sel       (sel),
    .data_in   (data_in),
    .addr_wr   (addr_wr),
    .addr_rd_0 (addr_rd_0),
    .addr_rd_1 (addr_rd_1),
    .data_out_0(data_out_0),
    .data_out_1(data_out_1)
  );

  typedef struct {
    logic [63:0] e0;
    logic [63:0] e1;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  logic [63:0] model[32];
  int          checks = 0;
  int          errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: byte k counts from the MSB; enable set follows the sel table.
  function automatic bit lane_on(input logic [2:0] s, input int k);
    case (s)
      3'd0:    return 1'b1;
      3'd1:    return k <= 3;
      3'd2:    return k >= 4;
      3'd3:    return (k % 2) == 0;
      3'd4:    return (k % 2) == 1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [63:0] model_merge(input logic [63:0] old, input logic [63:0] din,
                                              input logic [2:0] s);
    logic [63:0] r;
    r = old;
    for (int k = 0; k < 8; k++) begin
      if (lane_on(s, k)) r[63-8*k -: 8] = din[63-8*k -: 8];
    end
    return r;
  endfunction

  function automatic logic [63:0] model_read(input logic [4:0] ra);
    if (we && !reset && ra == addr_wr) return model_merge(model[addr_wr], data_in, sel);
    return model[ra];
  endfunction

  // Final contents after the 0x1111.. overwrite sequence, straight from the table.
  function automatic logic [63:0] seq_final(input int n);
    case (n % 8)
      0:       return 64'h1111_1111_1111_1111;
      1:       return 64'h1111_1111_FFFF_FFFF;
      2:       return 64'hFFFF_FFFF_1111_1111;
      3:       return 64'h11FF_11FF_11FF_11FF;
      4:       return 64'hFF11_FF11_FF11_FF11;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  task automatic drive(input logic w, input logic [2:0] s, input logic [63:0] d,
                       input logic [4:0] aw, input logic [4:0] a0, input logic [4:0] a1);
    we = w; sel = s; data_in = d; addr_wr = aw; addr_rd_0 = a0; addr_rd_1 = a1;
  endtask

  task automatic push(input logic [63:0] e0, input logic [63:0] e1, input string name);
    exp_t e;
    e.e0 = e0; e.e1 = e1; e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic push_model(input string name);
    push(model_read(addr_rd_0), model_read(addr_rd_1), name);
  endtask

  // Advance one clock; model commits the write seen at the edge.
  task automatic tick();
    @(posedge clk);
    if (we && !reset) model[addr_wr] = model_merge(model[addr_wr], data_in, sel);
    #1;
  endtask

  task automatic cycle(input logic w, input logic [2:0] s, input logic [63:0] d,
                       input logic [4:0] aw, input logic [4:0] a0, input logic [4:0] a1,
                       input string name);
    drive(w, s, d, aw, a0, a1);
    push_model(name);
    tick();
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 64'h0;
  endtask

  // Monitor: one expectation per cycle, checked mid-cycle away from the edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      checks += 2;
      if (data_out_0 !== e.e0) begin
        errors++;
        $display("FAIL %s port0 got %h want %h (t=%0t)", e.name, data_out_0, e.e0, $time);
      end
      if (data_out_1 !== e.e1) begin
        errors++;
        $display("FAIL %s port1 got %h want %h (t=%0t)", e.name, data_out_1, e.e1, $time);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] aw, a0, a1;
    reset = 1'b0;
    drive(1'b0, 3'd0, 64'h0, 5'd0, 5'd0, 5'd0);
    #2 reset = 1'b1;
    clear_model();
    @(posedge clk); #1;

    // Outputs read zero while reset is held.
    for (int i = 0; i < 3; i++) cycle(1'b0, 3'd0, 64'h0, 5'd0, 5'(i * 7), 5'(31 - i), "reset_hold");
    reset = 1'b0;

    // Read sweep after reset: all zero.
    for (int i = 0; i < 32; i++) cycle(1'b0, 3'd0, 64'h0, 5'd0, 5'(i), 5'(31 - i), "zero_sweep");

    // Full writes of all-F with forwarding on both ports.
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 5'(i), 5'(i), 5'(i));
      push(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, "fill_fwd");
      tick();
    end
    for (int i = 0; i < 32; i++) cycle(1'b0, 3'd0, 64'h0, 5'd0, 5'(i), 5'(i), "fill_sweep");

    // Partial writes, sel = n mod 8; forwarded value must be the final value.
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 3'(i % 8), 64'h1111_1111_1111_1111, 5'(i), 5'(i), 5'(i));
      push(seq_final(i), seq_final(i), "partial_fwd");
      tick();
    end
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 3'd0, 64'h0, 5'd0, 5'(i), 5'((i + 1) % 32));
      push(seq_final(i), seq_final((i + 1) % 32), "partial_final");
      tick();
    end

    // Asynchronous reset mid-cycle: outputs clear before the next edge.
    drive(1'b0, 3'd0, 64'h0, 5'd0, 5'd0, 5'd1);
    #2 reset = 1'b1;
    clear_model();
    push(64'h0, 64'h0, "async_reset");
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) cycle(1'b0, 3'd0, 64'h0, 5'd0, 5'(i + 2), 5'(i + 20), "reset_hold2");
    reset = 1'b0;
    for (int i = 0; i < 32; i++) cycle(1'b0, 3'd0, 64'h0, 5'd0, 5'(i), 5'(31 - i), "post_reset");

    // A write coinciding with reset is discarded.
    reset = 1'b1;
    cycle(1'b1, 3'd0, 64'hDEAD_BEEF_0123_4567, 5'd9, 5'd3, 5'd4, "reset_we");
    reset = 1'b0;
    cycle(1'b0, 3'd0, 64'h0, 5'd0, 5'd9, 5'd9, "reset_we_after");

    // Forward on port 0 only, stored value on port 1; reserved sel forwards old value.
    cycle(1'b1, 3'd0, 64'h6666_6666_6666_6666, 5'd6, 5'd0, 5'd1, "prep6");
    cycle(1'b1, 3'd0, 64'h0505_0505_0505_0505, 5'd5, 5'd0, 5'd6, "prep5");
    cycle(1'b1, 3'd2, 64'hA5A5_A5A5_A5A5_A5A5, 5'd5, 5'd5, 5'd6, "fwd_split");
    cycle(1'b1, 3'd6, 64'h1234_5678_9ABC_DEF0, 5'd5, 5'd5, 5'd5, "reserved_sel");
    cycle(1'b0, 3'd0, 64'h0, 5'd0, 5'd5, 5'd6, "split_after");

    // Random traffic with frequent address collisions.
    for (int i = 0; i < 400; i++) begin
      aw = 5'($urandom_range(0, 31));
      a0 = ($urandom_range(0, 2) == 0) ? aw : 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 2) == 0) ? aw : 5'($urandom_range(0, 31));
      cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), {$urandom, $urandom},
            aw, a0, a1, "random");
    end

    drive(1'b0, 3'd0, 64'h0, 5'd0, 5'd0, 5'd0);
    repeat (2) @(negedge clk);
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain queue left %0d want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameters SHALL be declared one per line (name, default, meaning):
- ADDR_WIDTH, default 5, register address width (2**ADDR_WIDTH entries).
- DATA_WIDTH, default 64, register width in bits (byte-lane logic assumes 64).

REQ-002 Ports SHALL be declared one per line (name, direction, width, meaning):
- clk, input, 1, single clock, rising edge active.
- reset, input, 1, asynchronous active-high reset.
- we, input, 1, write enable.
- sel, input, [0:2], PPP partial-write select.
- data_in, input, [0:DATA_WIDTH-1], write data.
- addr_wr, input, [0:ADDR_WIDTH-1], write address.
- addr_rd_0, input, [0:ADDR_WIDTH-1], read port 0 address.
- addr_rd_1, input, [0:ADDR_WIDTH-1], read port 1 address.
- data_out_0, output, [0:DATA_WIDTH-1], read port 0 data.
- data_out_1, output, [0:DATA_WIDTH-1], read port 1 data.

REQ-003 There SHALL be one clock; reset SHALL be asynchronous and active-high.

REQ-004 All vectors SHALL use big-endian numbering: bit 0 is the MSB, and byte k is bits [8k:8k+7], with k = 0..7.

Function
REQ-005 The block SHALL hold 32 registers of 64 bits, $0..$31. All are writable; none is hardwired to zero.

REQ-006 A write SHALL occur on the rising clk edge when we=1 and reset=0. Only the byte lanes enabled by sel are updated; the other lanes keep their old value.

REQ-007 sel decoding (enabled bytes) SHALL be:
- 000: all bytes 0-7.
- 001: upper half, bytes 0-3.
- 010: lower half, bytes 4-7.
- 011: even bytes 0, 2, 4, 6.
- 100: odd bytes 1, 3, 5, 7.
- 101/110/111: reserved, no bytes enabled, so no register changes.

REQ-008 Reads SHALL be combinational and have zero latency. data_out_N reflects the register at addr_rd_N in the same cycle.

REQ-009 Internal forwarding: when we=1 and addr_rd_N==addr_wr, data_out_N SHALL equal the merged write value. The merged value is data_in on the sel-enabled bytes and the current register contents on the other bytes. This applies to each port independently and to both ports together.

REQ-010 With we=0, or with a non-matching address, data_out_N SHALL be the stored register value.

REQ-011 Both read ports MAY address the same register simultaneously and SHALL return identical data.

REQ-012 Writing a reserved sel with we=1 SHALL forward the unchanged register value.

Reset
REQ-013 While reset=1, all 32 registers SHALL be cleared to 64'h0 immediately, without waiting for a clock edge.

REQ-014 reset SHALL override we. A write coinciding with reset asserted is discarded.

REQ-015 While reset=1 and no write is forwarded, data_out_0 and data_out_1 SHALL read 64'h0.

REQ-016 Asserting reset in the middle of a write sequence SHALL clear every register, including any being written.

Verification
REQ-017 Reset, then we=0, then sweep addr_rd_0 over 0..31 -> every read returns 0000_0000_0000_0000.

REQ-018 we=1, sel=000, data_in=FFFF_FFFF_FFFF_FFFF, with addr_wr, addr_rd_0 and addr_rd_1 all equal and stepped 0..31 one per cycle:
- Both outputs show FFFF_FFFF_FFFF_FFFF in the write cycle, before the edge (forwarding).
- Every register holds FFFF_FFFF_FFFF_FFFF afterwards.

REQ-019 From the all-F state, for n = 0..31 write register n with data_in=1111_1111_1111_1111 and sel = n mod 8. The final contents SHALL be:
- $0: 1111_1111_1111_1111
- $1: 1111_1111_FFFF_FFFF
- $2: FFFF_FFFF_1111_1111
- $3: 11FF_11FF_11FF_11FF
- $4: FF11_FF11_FF11_FF11
- $5, $6, $7: FFFF_FFFF_FFFF_FFFF
- $8..$31: follow the same pattern, with sel = n mod 8.

REQ-020 In the REQ-019 sequence, the forwarded outputs in each write cycle SHALL equal that register's final value listed in REQ-019.

REQ-021 Assert reset asynchronously between clock edges after REQ-019 -> all outputs read 0 at once, and the register sweep is all zeros.

REQ-022 we=1, addr_wr=5, addr_rd_0=5, addr_rd_1=6 -> data_out_0 is forwarded and data_out_1 is the stored $6.
